breakout_sfx: RTL

BREAKOUT_SFX -- requirements
Module: breakout_sfx

---
 rtl/breakout_sfx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/breakout_sfx.sv
// breakout_sfx: PIO-commanded square-wave tone generator for game sound effects.
// Defining SFX_QUEUE_EN adds a 4-deep {duration, id} command FIFO with a sticky overflow flag.
module breakout_sfx #(
    parameter int unsigned US_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pio_in,
    output logic       spk,
    output logic       busy,
    output logic [2:0] cur_id,
    output logic       overflow,
    output logic       dbg_state
);
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    localparam logic [15:0] PRESC_MAX    = 16'(US_DIV - 1);
    localparam logic [9:0]  US_PER_MS_M1 = 10'd999;

    state_t      state_q;
    logic [7:0]  pio_q;
    logic        toggle_prev_q;
    logic        first_q;
    logic        spk_q;
    logic        busy_q;
    logic [2:0]  cur_id_q;
    logic [3:0]  dur_q;
    logic [15:0] presc_q;
    logic [10:0] half_q;
    logic [9:0]  us_q;
    logic [7:0]  ms_q;

    logic        cmd_fire;
    logic        tick;
    logic        half_hit;
    logic        expire;
    logic        start_en;
    logic        stop_en;
    logic [2:0]  cmd_id;
    logic [3:0]  cmd_dur;
    logic [2:0]  start_id;
    logic [3:0]  start_dur;
    logic [10:0] half_lim;

`ifdef SFX_QUEUE_EN
    logic [6:0]  q_mem_q [4];
    logic [1:0]  q_rd_q;
    logic [2:0]  q_cnt_q;
    logic        overflow_q;
    logic        q_empty;
    logic        q_flush;
    logic        q_pop;
    logic        q_push;
    logic        q_accept;
    logic [1:0]  q_wr;
`endif

    // Half-period limits are stored minus one so the compare hits on the last tick.
    always_comb begin
        case (cur_id_q)
            3'd1:    half_lim = 11'd1910;
            3'd2:    half_lim = 11'd1516;
            3'd3:    half_lim = 11'd1275;
            3'd4:    half_lim = 11'd955;
            3'd5:    half_lim = 11'd757;
            3'd6:    half_lim = 11'd637;
            3'd7:    half_lim = 11'd477;
            default: half_lim = 11'd2047;
        endcase
    end

    always_comb begin
        cmd_fire  = !first_q && (pio_q[7] != toggle_prev_q);
        cmd_id    = pio_q[2:0];
        cmd_dur   = pio_q[6:3];
        tick      = (presc_q == PRESC_MAX);
        half_hit  = tick && (half_q == half_lim);
        expire    = (state_q == PLAY) && tick && (us_q == US_PER_MS_M1) &&
                    (ms_q == {dur_q, 4'hF});
        start_id  = cmd_id;
        start_dur = cmd_dur;
        stop_en   = (cmd_fire && (cmd_id == 3'd0)) || expire;
`ifdef SFX_QUEUE_EN
        q_empty  = (q_cnt_q == 3'd0);
        q_flush  = cmd_fire && (cmd_id == 3'd0);
        q_pop    = expire && !q_empty && !q_flush;
        q_push   = cmd_fire && (cmd_id != 3'd0) && (state_q == PLAY) && !(expire && q_empty);
        q_accept = q_push && ((q_cnt_q != 3'd4) || q_pop);
        q_wr     = q_rd_q + q_cnt_q[1:0];
        start_en = (cmd_fire && (cmd_id != 3'd0) && ((state_q == IDLE) || (expire && q_empty)))
                   || q_pop;
        if (q_pop) begin
            {start_dur, start_id} = q_mem_q[q_rd_q];
        end
`else
        start_en = cmd_fire && (cmd_id != 3'd0);
`endif
    end

    // Start has priority over stop so a command coinciding with expiry re-enters PLAY.
    always_ff @(posedge clk) begin
        pio_q <= pio_in;
        if (reset) begin
            state_q       <= IDLE;
            first_q       <= 1'b1;
            toggle_prev_q <= 1'b0;
            spk_q         <= 1'b0;
            busy_q        <= 1'b0;
            cur_id_q      <= 3'd0;
            dur_q         <= 4'd0;
            presc_q       <= 16'd0;
            half_q        <= 11'd0;
            us_q          <= 10'd0;
            ms_q          <= 8'd0;
        end else begin
            first_q <= 1'b0;
            if (first_q || cmd_fire) begin
                toggle_prev_q <= pio_q[7];
            end
            if (start_en) begin
                state_q  <= PLAY;
                spk_q    <= 1'b0;
                busy_q   <= 1'b1;
                cur_id_q <= start_id;
                dur_q    <= start_dur;
                presc_q  <= 16'd0;
                half_q   <= 11'd0;
                us_q     <= 10'd0;
                ms_q     <= 8'd0;
            end else if (stop_en) begin
                state_q  <= IDLE;
                spk_q    <= 1'b0;
                busy_q   <= 1'b0;
                cur_id_q <= 3'd0;
                presc_q  <= 16'd0;
                half_q   <= 11'd0;
                us_q     <= 10'd0;
                ms_q     <= 8'd0;
            end else if (state_q == PLAY) begin
                presc_q <= tick ? 16'd0 : presc_q + 16'd1;
                if (tick) begin
                    half_q <= half_hit ? 11'd0 : half_q + 11'd1;
                    spk_q  <= spk_q ^ half_hit;
                    if (us_q == US_PER_MS_M1) begin
                        us_q <= 10'd0;
                        ms_q <= ms_q + 8'd1;
                    end else begin
                        us_q <= us_q + 10'd1;
                    end
                end
            end
        end
    end

`ifdef SFX_QUEUE_EN
    // A full FIFO still accepts a push on the edge where its head is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_rd_q     <= 2'd0;
            q_cnt_q    <= 3'd0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                q_mem_q[i] <= 7'd0;
            end
        end else if (q_flush) begin
            q_rd_q  <= 2'd0;
            q_cnt_q <= 3'd0;
        end else begin
            if (q_accept) begin
                q_mem_q[q_wr] <= {cmd_dur, cmd_id};
            end
            if (q_push && !q_accept) begin
                overflow_q <= 1'b1;
            end
            if (q_pop) begin
                q_rd_q <= q_rd_q + 2'd1;
            end
            q_cnt_q <= q_cnt_q + {2'b00, q_accept} - {2'b00, q_pop};
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign spk       = spk_q;
    assign busy      = busy_q;
    assign cur_id    = cur_id_q;
    assign dbg_state = state_q;
endmodule
